// File: rtl/sr_debounce.sv
// Debouncer for a pair of raw set/reset push-buttons feeding a downstream SR
// flip-flop stage; each channel has its own synchronizer, FSM and counter.
module sr_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic clk,
  input  logic Clear_n,
  input  logic S_btn,
  input  logic R_btn,
  output logic S,
  output logic R,
  output logic S_pulse,
  output logic R_pulse,
  output logic Invalid
);

  typedef enum logic [1:0] {
    STABLE0 = 2'd0,
    CHK1    = 2'd1,
    STABLE1 = 2'd2,
    CHK0    = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0] raw;
  logic [1:0] lvl;
  logic [1:0] pulse;

  // Channel 0 is set, channel 1 is reset.
  assign raw = {R_btn, S_btn};

  for (genvar g = 0; g < 2; g++) begin : g_ch
    logic             meta_q;
    logic             sync_q;
    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             lvl_q;
    logic             lvl_d;
    logic             pulse_q;
    logic             pulse_d;

    // Stage 0: two-flop synchronizer on the raw button
    always_ff @(posedge clk or negedge Clear_n) begin
      if (!Clear_n) begin
        meta_q <= 1'b0;
        sync_q <= 1'b0;
      end else begin
        meta_q <= raw[g];
        sync_q <= meta_q;
      end
    end

    // Stage 1: debounce FSM, counter and registered outputs
    always_ff @(posedge clk or negedge Clear_n) begin
      if (!Clear_n) begin
        state_q <= STABLE0;
        cnt_q   <= '0;
        lvl_q   <= 1'b0;
        pulse_q <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        lvl_q   <= lvl_d;
        pulse_q <= pulse_d;
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pulse_d = 1'b0;
      unique case (state_q)
        STABLE0: begin
          if (sync_q) begin
            state_d = CHK1;
            cnt_d   = '0;
          end
        end
        CHK1: begin
          if (!sync_q) begin
            state_d = STABLE0;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = STABLE1;
            cnt_d   = '0;
            pulse_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        STABLE1: begin
          if (!sync_q) begin
            state_d = CHK0;
            cnt_d   = '0;
          end
        end
        CHK0: begin
          if (sync_q) begin
            state_d = STABLE1;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = STABLE0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = STABLE0;
          cnt_d   = '0;
        end
      endcase
      // A level is held high while a falling check is still pending.
      lvl_d = (state_d == STABLE1) || (state_d == CHK0);
    end

    assign lvl[g]   = lvl_q;
    assign pulse[g] = pulse_q;
  end

  // Stage 2: output mapping; Invalid is purely combinational on the registered levels
  assign S       = lvl[0];
  assign R       = lvl[1];
  assign S_pulse = pulse[0];
  assign R_pulse = pulse[1];
  assign Invalid = lvl[0] & lvl[1];

endmodule

// File: doc/sr_debounce.md
SR_DEBOUNCE -- requirements
Module: sr_debounce

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, giving the number of consecutive stable clk cycles required to accept a new level; legal range 1 to 2^CNT_W-1.
REQ-002 SHALL have parameter CNT_W, default 19, giving the width of each debounce counter.
REQ-003 SHALL have port clk  input  1  the single system clock; all state is updated on its rising edge.
REQ-004 SHALL have port Clear_n  input  1  asynchronous active-low reset; assertion takes effect immediately, independent of clk.
REQ-005 SHALL have port S_btn  input  1  raw, asynchronous, bouncing set push-button.
REQ-006 SHALL have port R_btn  input  1  raw, asynchronous, bouncing reset push-button.
REQ-007 SHALL have port S  output  1  debounced set level; this drives the S input of the downstream SR flip-flop stage.
REQ-008 SHALL have port R  output  1  debounced reset level; this drives the R input of the downstream SR flip-flop stage.
REQ-009 SHALL have port S_pulse  output  1  one-cycle strobe marking acceptance of a rising S level.
REQ-010 SHALL have port R_pulse  output  1  one-cycle strobe marking acceptance of a rising R level.
REQ-011 SHALL have port Invalid  output  1  high when S and R are both 1, which is the forbidden SR combination.

Function
REQ-012 SHALL pass each raw input through its own 2-flop synchronizer before any other use.
REQ-013 SHALL give each channel an independent FSM with the states STABLE0, CHK1, STABLE1 and CHK0, plus its own CNT_W-bit counter.
REQ-014 STABLE0 SHALL move to CHK1 and clear its counter to 0 when the synchronized input is 1; otherwise it SHALL hold.
REQ-015 In CHK1, synchronized input 0 SHALL abort the check: return to STABLE0, discard the count, emit no pulse.
REQ-016 In CHK1, synchronized input 1 with counter < DEBOUNCE_CYCLES-1 SHALL increment the counter by 1.
REQ-017 In CHK1, synchronized input 1 with counter = DEBOUNCE_CYCLES-1 SHALL move the FSM to STABLE1.
REQ-018 STABLE1 and CHK0 SHALL mirror REQ-014 to REQ-017 with the polarities inverted, returning to STABLE0 on acceptance; a falling acceptance SHALL produce no pulse.
REQ-019 The counter SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap around.
REQ-020 S and R SHALL be registered outputs and SHALL equal 1 exactly when their channel is in STABLE1 or CHK0.
REQ-021 With the raw input stable, an output change SHALL appear exactly DEBOUNCE_CYCLES+3 rising clk edges after the first edge that samples the new raw level.
REQ-022 S_pulse and R_pulse SHALL be registered and SHALL be high for exactly one cycle, namely the first cycle in which S or R (respectively) reads 1.
REQ-023 Invalid SHALL equal S AND R on every cycle, with no added latency; both channels SHALL continue filtering normally while Invalid is high.
REQ-024 The two channels SHALL be fully independent; simultaneous edges on S_btn and R_btn SHALL each be debounced without interaction.
REQ-025 Glitches shorter than 2 cycles SHALL either be removed by the synchronizer or abort a CHK state; a glitch SHALL never change S or R.

Reset
REQ-026 While Clear_n = 0: synchronizers = 0, counters = 0, both FSMs = STABLE0, and S, R, S_pulse, R_pulse, Invalid = 0.
REQ-027 Reset asserted mid-check SHALL discard all progress.
REQ-028 After Clear_n deasserts, any input already held high SHALL undergo a full fresh debounce per REQ-021 and SHALL produce exactly one pulse.

Verification (bench uses DEBOUNCE_CYCLES = 4)
REQ-029 Clear_n = 0, S_btn = R_btn = 1 -> all outputs 0 throughout reset; after release, S and R rise together at edge 7, S_pulse and R_pulse high for one cycle at edge 7, and Invalid = 1 from that cycle.
REQ-030 S_btn 0->1 held -> S = 1 at edge 7 after the first sampling edge, S_pulse high only in that cycle, R = 0 throughout.
REQ-031 S_btn toggling high 3 cycles / low 1 cycle repeatedly, then held high -> S stays 0 during toggling, then rises 7 edges after the final rising edge, with a single S_pulse.
REQ-032 S stable at 1, then S_btn falls -> S = 0 at edge 7 after the fall, no S_pulse; a 2-cycle low glitch leaves S at 1.
REQ-033 Clear_n pulsed low while R_btn is high and the channel is in CHK1 with counter = 2 -> R = 0 and no R_pulse; after release, R rises at edge 7 with one R_pulse.
REQ-034 S_btn and R_btn rising on the same edge, with R_btn dropping after 2 cycles -> S = 1 at edge 7, R remains 0, Invalid never asserts.
